// File: rtl/ooo_mem_arbiter.sv
// ooo_mem_arbiter: two-master (icache, dcache) to one-slave arbiter on the
// generic bus protocol. Data requests have fixed priority over instruction.
// Each granted request is latched and held until the slave completes it.
// The response is then routed back to the master that owns the transaction.
//
// Ports:
//   CLK, nRST                         clock, async active-low reset
//   i_addr, i_ren                     icache request
//   i_busy, i_rdata                   icache response (busy=0 on completion)
//   d_addr, d_wdata, d_ren, d_wen,
//   d_byte_en                         dcache request
//   d_busy, d_rdata                   dcache response (busy=0 on completion)
//   o_addr, o_wdata, o_ren, o_wen,
//   o_byte_en                         outbound request to the slave
//   o_rdata, o_busy                   slave response (busy=0 means done)
//
// Optional macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive dcache
// grants made while the icache waits, the next grant goes to the icache.
module ooo_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_ren,
    output logic                i_busy,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [DATA_W/8-1:0] d_byte_en,
    output logic                d_busy,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   o_addr,
    output logic [DATA_W-1:0]   o_wdata,
    output logic                o_ren,
    output logic                o_wen,
    output logic [DATA_W/8-1:0] o_byte_en,
    input  logic [DATA_W-1:0]   o_rdata,
    input  logic                o_busy
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] wdata_q, wdata_nx;
    logic [BE_W-1:0]   be_q, be_nx;
    logic              ren_q, ren_nx;
    logic              wen_q, wen_nx;
    logic              take_i, take_d;
    logic              i_done, d_done;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_q, starve_nx;
    logic       starved;

    // icache has waited through STARVE_MAX dcache grants: it wins next
    assign starved = i_ren && (starve_q == 3'(STARVE_MAX));
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
`endif

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        be_nx    = be_q;
        ren_nx   = ren_q;
        wen_nx   = wen_q;
        take_i   = 1'b0;
        take_d   = 1'b0;
        unique case (state)
            IDLE: begin
`ifdef ARB_STARVE_GUARD_EN
                if ((d_ren || d_wen) && !starved)
                    take_d = 1'b1;
                else if (i_ren)
                    take_i = 1'b1;
`else
                if (d_ren || d_wen)
                    take_d = 1'b1;
                else if (i_ren)
                    take_i = 1'b1;
`endif
                if (take_d) begin
                    state_nx = GRANT_D;
                    addr_nx  = d_addr;
                    wdata_nx = d_wdata;
                    be_nx    = d_byte_en;
                    // read+write together is issued as a write
                    wen_nx   = d_wen;
                    ren_nx   = d_ren && !d_wen;
                end else if (take_i) begin
                    state_nx = GRANT_I;
                    addr_nx  = i_addr;
                    wdata_nx = '0;
                    be_nx    = '1;
                    wen_nx   = 1'b0;
                    ren_nx   = 1'b1;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!o_busy) begin
                    state_nx = IDLE;
                    ren_nx   = 1'b0;
                    wen_nx   = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef ARB_STARVE_GUARD_EN
    always_comb begin
        starve_nx = starve_q;
        if (take_i)
            starve_nx = 3'd0;
        else if (take_d && i_ren && starve_q != 3'd7)
            starve_nx = starve_q + 3'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            starve_q <= 3'd0;
        else
            starve_q <= starve_nx;
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
            be_q    <= be_nx;
            ren_q   <= ren_nx;
            wen_q   <= wen_nx;
        end
    end

    assign o_addr    = addr_q;
    assign o_wdata   = wdata_q;
    assign o_byte_en = be_q;
    assign o_ren     = ren_q;
    assign o_wen     = wen_q;

    // completion is visible only to the owner, only in the done cycle
    assign i_done  = (state == GRANT_I) && !o_busy;
    assign d_done  = (state == GRANT_D) && !o_busy;
    assign i_busy  = !i_done;
    assign d_busy  = !d_done;
    assign i_rdata = i_done ? o_rdata : '0;
    assign d_rdata = d_done ? o_rdata : '0;

endmodule

// File: tb/tb_ooo_mem_arbiter.sv
// tb_ooo_mem_arbiter: directed self-checking bench for ooo_mem_arbiter.
// The bench drives the slave side directly with hand-chosen busy/rdata.
module tb_ooo_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ren = 1'b0;
    logic        i_busy;
    logic [31:0] i_rdata;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ren = 1'b0;
    logic        d_wen = 1'b0;
    logic [3:0]  d_byte_en = '0;
    logic        d_busy;
    logic [31:0] d_rdata;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic        o_ren;
    logic        o_wen;
    logic [3:0]  o_byte_en;
    logic [31:0] o_rdata = '0;
    logic        o_busy = 1'b1;

    int nchk = 0;
    int nerr = 0;

    ooo_mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .i_addr(i_addr), .i_ren(i_ren),
        .i_busy(i_busy), .i_rdata(i_rdata),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ren(d_ren), .d_wen(d_wen),
        .d_byte_en(d_byte_en),
        .d_busy(d_busy), .d_rdata(d_rdata),
        .o_addr(o_addr), .o_wdata(o_wdata),
        .o_ren(o_ren), .o_wen(o_wen),
        .o_byte_en(o_byte_en),
        .o_rdata(o_rdata), .o_busy(o_busy)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        o_rdata = 32'hFFFF_FFFF;
        o_busy  = 1'b0;
        i_ren   = 1'b1;
        d_ren   = 1'b1;
        #2;
        nchk++;
        if ({o_ren, o_wen} !== 2'b00) begin
            nerr++;
            $display("FAIL reset_ren_wen: got %b want 00", {o_ren, o_wen});
        end
        nchk++;
        if ({o_addr, o_wdata, o_byte_en} !== 68'd0) begin
            nerr++;
            $display("FAIL reset_out: got %h/%h/%h want 0", o_addr, o_wdata, o_byte_en);
        end
        nchk++;
        if ({i_busy, d_busy} !== 2'b11) begin
            nerr++;
            $display("FAIL reset_busy: got %b want 11", {i_busy, d_busy});
        end
        nchk++;
        if ({i_rdata, d_rdata} !== 64'd0) begin
            nerr++;
            $display("FAIL reset_rdata: got %h/%h want 0", i_rdata, d_rdata);
        end
        i_ren   = 1'b0;
        d_ren   = 1'b0;
        o_busy  = 1'b1;
        o_rdata = '0;
        #1 nRST = 1'b1;
        step();
    endtask

    task automatic test_icache_read();
        int done = 0;
        i_addr = 32'h0000_0100;
        i_ren  = 1'b1;
        step();
        i_ren = 1'b0;
        #1;
        nchk++;
        if ({o_ren, o_wen, o_byte_en} !== 6'b10_1111) begin
            nerr++;
            $display("FAIL ird_req: got %b want 101111", {o_ren, o_wen, o_byte_en});
        end
        nchk++;
        if (o_addr !== 32'h100) begin
            nerr++;
            $display("FAIL ird_addr: got %h want 100", o_addr);
        end
        for (int k = 0; k < 3; k++) begin
            if (!i_busy) done++;
            nchk++;
            if ({o_ren, d_busy} !== 2'b11) begin
                nerr++;
                $display("FAIL ird_wait%0d: got ren/dbusy %b want 11", k, {o_ren, d_busy});
            end
            if (k < 2) step();
        end
        step();
        o_busy  = 1'b0;
        o_rdata = 32'hDEAD_BEEF;
        #1;
        if (!i_busy) done++;
        nchk++;
        if (i_rdata !== 32'hDEAD_BEEF || d_busy !== 1'b1 || d_rdata !== 32'd0) begin
            nerr++;
            $display("FAIL ird_done: got %h dbusy %b drd %h want deadbeef 1 0", i_rdata, d_busy, d_rdata);
        end
        step();
        o_busy = 1'b1;
        #1;
        if (!i_busy) done++;
        nchk++;
        if (o_ren !== 1'b0) begin
            nerr++;
            $display("FAIL ird_idle: got ren %b want 0", o_ren);
        end
        nchk++;
        if (done !== 1) begin
            nerr++;
            $display("FAIL ird_count: got %0d want 1", done);
        end
    endtask

    task automatic test_simultaneous();
        i_addr    = 32'h400;
        i_ren     = 1'b1;
        d_addr    = 32'h200;
        d_wdata   = 32'h1234_5678;
        d_byte_en = 4'b0011;
        d_wen     = 1'b1;
        step();
        nchk++;
        if ({o_wen, o_ren, o_byte_en} !== 6'b10_0011) begin
            nerr++;
            $display("FAIL sim_wr: got %b want 100011", {o_wen, o_ren, o_byte_en});
        end
        nchk++;
        if (o_addr !== 32'h200 || o_wdata !== 32'h1234_5678) begin
            nerr++;
            $display("FAIL sim_wr_data: got %h/%h want 200/12345678", o_addr, o_wdata);
        end
        d_addr = 32'h300;
        step();
        nchk++;
        if (o_addr !== 32'h200) begin
            nerr++;
            $display("FAIL hold_addr: got %h want 200", o_addr);
        end
        d_wen  = 1'b0;
        o_busy = 1'b0;
        #1;
        nchk++;
        if ({d_busy, i_busy} !== 2'b01) begin
            nerr++;
            $display("FAIL sim_wr_done: got %b want 01", {d_busy, i_busy});
        end
        step();
        o_busy = 1'b1;
        #1;
        nchk++;
        if ({o_ren, o_wen} !== 2'b00) begin
            nerr++;
            $display("FAIL sim_gap: got %b want 00", {o_ren, o_wen});
        end
        step();
        nchk++;
        if ({o_ren, o_wen, o_byte_en} !== 6'b10_1111 || o_addr !== 32'h400) begin
            nerr++;
            $display("FAIL sim_rd: got %b addr %h want 101111 400", {o_ren, o_wen, o_byte_en}, o_addr);
        end
        i_ren   = 1'b0;
        o_busy  = 1'b0;
        o_rdata = 32'hCAFE_F00D;
        #1;
        nchk++;
        if (i_busy !== 1'b0 || i_rdata !== 32'hCAFE_F00D || d_busy !== 1'b1) begin
            nerr++;
            $display("FAIL sim_rd_done: got %b %h %b want 0 cafef00d 1", i_busy, i_rdata, d_busy);
        end
        step();
        o_busy = 1'b1;
    endtask

    task automatic test_back_to_back();
        i_addr  = 32'h500;
        o_rdata = 32'h11;
        o_busy  = 1'b0;
        i_ren   = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            nchk++;
            if ({o_ren, i_busy} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
                nerr++;
                $display("FAIL b2b_c%0d: got ren/ibusy %b want %b", k, {o_ren, i_busy},
                         (k % 2 == 1) ? 2'b10 : 2'b01);
            end
            step();
        end
        i_ren = 1'b0;
        step();
        o_busy = 1'b1;
    endtask

    task automatic test_priority();
        logic [31:0] exp;
        int g = 0;
        d_addr = 32'h600;
        i_addr = 32'h700;
        d_ren  = 1'b1;
        i_ren  = 1'b1;
        o_busy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            nchk++;
            if (!i_busy && !d_busy) begin
                nerr++;
                $display("FAIL prio_both_c%0d: got busy 00 want not 00", c);
            end
            if (o_ren) begin
`ifdef ARB_STARVE_GUARD_EN
                exp = (g == 4) ? 32'h700 : 32'h600;
`else
                exp = 32'h600;
`endif
                nchk++;
                if (o_addr !== exp) begin
                    nerr++;
                    $display("FAIL prio_g%0d: got %h want %h", g, o_addr, exp);
                end
                g++;
            end
        end
        nchk++;
        if (g !== 6) begin
            nerr++;
            $display("FAIL prio_ngrant: got %0d want 6", g);
        end
        d_ren = 1'b0;
        i_ren = 1'b0;
        step();
        step();
        o_busy = 1'b1;
    endtask

    task automatic test_reset_mid();
        d_addr = 32'h800;
        d_ren  = 1'b1;
        step();
        d_ren = 1'b0;
        nchk++;
        if (o_ren !== 1'b1) begin
            nerr++;
            $display("FAIL rmid_grant: got %b want 1", o_ren);
        end
        nRST = 1'b0;
        #1;
        nchk++;
        if ({o_ren, o_wen, d_busy} !== 3'b001 || o_addr !== 32'd0) begin
            nerr++;
            $display("FAIL rmid_reset: got %b addr %h want 001 0", {o_ren, o_wen, d_busy}, o_addr);
        end
        #1 nRST = 1'b1;
        step();
        nchk++;
        if (o_ren !== 1'b0) begin
            nerr++;
            $display("FAIL rmid_idle: got %b want 0", o_ren);
        end
        d_addr = 32'h900;
        d_ren  = 1'b1;
        step();
        d_ren = 1'b0;
        nchk++;
        if (o_ren !== 1'b1 || o_addr !== 32'h900) begin
            nerr++;
            $display("FAIL rmid_next: got %b %h want 1 900", o_ren, o_addr);
        end
        o_busy  = 1'b0;
        o_rdata = 32'h55AA;
        #1;
        nchk++;
        if (d_busy !== 1'b0 || d_rdata !== 32'h55AA) begin
            nerr++;
            $display("FAIL rmid_done: got %b %h want 0 55aa", d_busy, d_rdata);
        end
        step();
        o_busy = 1'b1;
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_simultaneous();
        test_back_to_back();
        test_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
